// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer layout constants and types shared by the packer and the display
package fb_pkg;
  localparam int FB_WORD_BITS = 32;
  localparam int FB_H_PIXELS = 640;
  localparam int FB_V_LINES = 480;
  localparam int FB_WORDS_PER_LINE = FB_H_PIXELS / FB_WORD_BITS;
  localparam int FB_FRAME_WORDS = FB_WORDS_PER_LINE * FB_V_LINES;
  localparam int FB_ADDR_W = 15;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_WORD_BITS-1:0] fb_word_t;
  typedef enum logic [1:0] {IDLE, PACK, CLEAR} packer_state_e;
endpackage

// File: rtl/fb_bit_packer.sv
// fb_bit_packer: assembles 32 pixels into a word, first pixel landing in bit 0
module fb_bit_packer
  import fb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     start,
  input  logic     en,
  input  logic     din,
  output fb_word_t word,
  output logic     word_ready
);
  logic [4:0] bit_cnt;
  fb_word_t shreg;
  // right shift: after 32 beats the oldest pixel sits in bit 0
  assign word = {din, shreg[FB_WORD_BITS-1:1]};
  assign word_ready = en && !start && &bit_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (en) begin
      shreg <= word;
      bit_cnt <= start ? 5'd1 : bit_cnt + 5'd1;
    end
  end
endmodule

// File: rtl/fb_stream_packer.sv
// fb_stream_packer: packs a 1bpp pixel stream into framebuffer writes and clears frames; FB_PACKER_STATS_EN adds frame/restart counters
module fb_stream_packer
  import fb_pkg::*;
#(
  parameter int H_PIXELS = FB_H_PIXELS,
  parameter int V_LINES = FB_V_LINES,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic              pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              clear_req,
  input  logic              clear_value,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       writedata,
  output logic              write,
  output logic              chipselect,
  output logic              busy,
  output logic              frame_done,
  output logic              clear_done
`ifdef FB_PACKER_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       sof_restart_count
`endif
);
  localparam int WORDS_PER_LINE = H_PIXELS / FB_WORD_BITS;
  localparam int FRAME_WORDS = WORDS_PER_LINE * V_LINES;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
  packer_state_e state, state_n;
  logic [ADDR_W-1:0] word_cnt, cnt_n, clr_idx, addr_n;
  fb_word_t pk_word, data_n;
  logic clear_val, pk_ready, acc, sof_acc, clr_go, clr_wr, pk_wr, pk_en, wr_n, fd_n, cd_n;
  assign pix_ready = state != CLEAR && !clear_req;
  assign acc = pix_valid && pix_ready;
  assign sof_acc = acc && pix_sof;
  assign pk_en = acc && (pix_sof || state == PACK);
  assign clr_go = clear_req && state != CLEAR;
  assign clr_wr = clr_go || state == CLEAR;
  // the clear engine issues word 0 on the request edge, so its index starts at 0 there
  assign clr_idx = clr_go ? '0 : word_cnt;
  assign pk_wr = state == PACK && pk_ready;
  assign chipselect = write;
  assign busy = state != IDLE;
  fb_bit_packer u_bits (
    .clk(clk),
    .reset(reset),
    .clr(clr_go),
    .start(sof_acc),
    .en(pk_en),
    .din(pix_data),
    .word(pk_word),
    .word_ready(pk_ready)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = cd_n ? IDLE : clr_go ? CLEAR : fd_n ? IDLE : (state == IDLE && sof_acc) ? PACK : state;
  end
  always_comb begin
    wr_n = clr_wr || pk_wr;
    cd_n = clr_wr && clr_idx == LAST;
    fd_n = pk_wr && word_cnt == LAST;
    addr_n = clr_idx;
    data_n = clr_wr ? {FB_WORD_BITS{clr_go ? clear_value : clear_val}} : pk_word;
    cnt_n = clr_wr ? clr_idx + 1'b1 : sof_acc ? '0 : pk_wr ? word_cnt + 1'b1 : word_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      clear_val <= 1'b0;
      address <= '0;
      writedata <= '0;
      write <= 1'b0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      word_cnt <= cnt_n;
      if (clr_go) clear_val <= clear_value;
      address <= addr_n;
      writedata <= data_n;
      write <= wr_n;
      frame_done <= fd_n;
      clear_done <= cd_n;
    end
  end
`ifdef FB_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      sof_restart_count <= '0;
    end else begin
      if (fd_n && !(&frame_count)) frame_count <= frame_count + 16'd1;
      if (sof_acc && state == PACK && !(&sof_restart_count)) sof_restart_count <= sof_restart_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_stream_packer.sv
// tb_fb_stream_packer: random and directed stimulus against a pixel-index reference model
module tb_fb_stream_packer;
  localparam int HP = 64;
  localparam int VL = 8;
  localparam int FW = HP / 32 * VL;
  logic clk, reset, pix_valid, pix_data, pix_sof, pix_ready, clear_req, clear_value;
  logic [14:0] address;
  logic [31:0] writedata;
  logic write, chipselect, busy, frame_done, clear_done;
`ifdef FB_PACKER_STATS_EN
  logic [15:0] frame_count, sof_restart_count;
`endif
  fb_stream_packer #(.H_PIXELS(HP), .V_LINES(VL), .ADDR_W(15)) dut (
    .clk(clk),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .clear_req(clear_req),
    .clear_value(clear_value),
    .address(address),
    .writedata(writedata),
    .write(write),
    .chipselect(chipselect),
    .busy(busy),
    .frame_done(frame_done),
    .clear_done(clear_done)
`ifdef FB_PACKER_STATS_EN
    ,
    .frame_count(frame_count),
    .sof_restart_count(sof_restart_count)
`endif
  );
  int checks = 0, failures = 0, cyc = 0;
  int m_mode = 0, m_pix = 0, m_ci = 0, m_fc = 0, m_src = 0, e_addr = 0;
  logic m_cv = 0, e_write = 0, e_fd = 0, e_cd = 0, e_rst = 0;
  logic [31:0] m_acc = '0, e_data = '0;
  int q_addr[$], q_cyc[$];
  logic [31:0] q_data[$];
  logic q_fd[$], q_cd[$];
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, got, exp, cyc);
    end
  endtask

  // reference: mode 0 idle, 1 packing (pixel index in frame), 2 clearing
  task automatic model_step();
    logic rdy;
    int b;
    e_write = 0; e_fd = 0; e_cd = 0; e_rst = reset;
    if (reset) begin
      m_mode = 0; e_addr = 0; e_data = '0; m_fc = 0; m_src = 0;
      return;
    end
    rdy = m_mode != 2 && !clear_req;
    if (m_mode != 2 && clear_req) begin
      m_mode = 2; m_cv = clear_value; m_ci = 0;
    end
    if (m_mode == 2) begin
      e_write = 1; e_addr = m_ci; e_data = {32{m_cv}};
      if (m_ci == FW - 1) begin e_cd = 1; m_mode = 0; end
      m_ci++;
    end else if (pix_valid && rdy) begin
      if (pix_sof) begin
        if (m_mode == 1 && m_src < 65535) m_src++;
        m_mode = 1; m_pix = 0;
      end
      if (m_mode == 1) begin
        b = m_pix % 32;
        m_acc[b] = pix_data;
        if (b == 31) begin
          e_write = 1; e_addr = m_pix / 32; e_data = m_acc;
          if (m_pix / 32 == FW - 1) begin
            e_fd = 1; m_mode = 0;
            if (m_fc < 65535) m_fc++;
          end
        end
        m_pix++;
      end
    end
  endtask

  task automatic compare();
    chk("write", 32'(write), 32'(e_write));
    chk("chipselect", 32'(chipselect), 32'(e_write));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("clear_done", 32'(clear_done), 32'(e_cd));
    chk("pix_ready", 32'(pix_ready), 32'(m_mode != 2 && !clear_req));
    if (e_write || e_rst) begin
      chk("address", 32'(address), e_addr);
      chk("writedata", writedata, e_data);
    end
`ifdef FB_PACKER_STATS_EN
    chk("frame_count", 32'(frame_count), m_fc);
    chk("sof_restart_count", 32'(sof_restart_count), m_src);
`endif
    if (write) begin
      q_addr.push_back(int'(address)); q_data.push_back(writedata); q_cyc.push_back(cyc);
      q_fd.push_back(frame_done); q_cd.push_back(clear_done);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic beat(input logic v, input logic d, input logic s, input logic cr, input logic cv);
    pix_valid = v; pix_data = d; pix_sof = s; clear_req = cr; clear_value = cv;
    cycle();
  endtask

  initial begin
    int n0, n1, c;
    reset = 1; pix_valid = 0; pix_data = 0; pix_sof = 0; clear_req = 0; clear_value = 0;
    repeat (3) cycle();
    chk("rst_write", 32'(write), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 0;
    beat(0, 0, 0, 0, 0);
    // full frame: white pixels only at (0,0) and (33,0)
    n0 = q_addr.size();
    for (int p = 0; p < HP * VL; p++)
      beat(1, p == 0 || p == 33, p == 0, 0, 0);
    beat(0, 0, 0, 0, 0);
    chk("frame_writes", q_addr.size() - n0, FW);
    for (int i = 0; i < FW; i++) begin
      chk("frame_addr", q_addr[n0+i], i);
      chk("frame_data", q_data[n0+i], i == 0 ? 32'h1 : i == 1 ? 32'h2 : 32'h0);
    end
    chk("frame_done_last", 32'(q_fd[n0+FW-1]), 1);
    // throughput: alternating pixels at full rate
    n0 = q_addr.size(); c = 0;
    for (int p = 0; p < 96; p++) begin
      if (p == 31) c = cyc;
      beat(1, p % 2 == 0, p == 0, 0, 0);
    end
    chk("tp_writes", q_addr.size() - n0, 3);
    chk("tp_latency", q_cyc[n0], c + 1);
    for (int i = 0; i < 3; i++) begin
      chk("tp_data", q_data[n0+i], 32'h55555555);
      if (i > 0) chk("tp_gap", q_cyc[n0+i] - q_cyc[n0+i-1], 32);
    end
    // priority: clear_req with a sof beat while packing
    pix_valid = 1; pix_data = 1; pix_sof = 1; clear_req = 1; clear_value = 0;
    #1 chk("prio_ready", 32'(pix_ready), 0);
    n0 = q_addr.size(); c = cyc;
    cycle();
    chk("prio_addr", q_addr[n0], 0);
    chk("prio_cyc", q_cyc[n0], c + 1);
    repeat (FW + 2) beat(0, 0, 0, 0, 0);
    // clear with ones from idle; beats offered meanwhile must be refused
    n0 = q_addr.size(); c = cyc;
    beat(0, 0, 0, 1, 1);
    for (int i = 0; i < FW - 1; i++) begin
      pix_valid = 1; pix_data = 1'($urandom_range(1, 0)); pix_sof = 0; clear_req = 0;
      #1 chk("clear_ready", 32'(pix_ready), 0);
      cycle();
    end
    repeat (3) beat(0, 0, 0, 0, 0);
    chk("clear_writes", q_addr.size() - n0, FW);
    for (int i = 0; i < FW; i++) begin
      chk("clear_addr", q_addr[n0+i], i);
      chk("clear_data", q_data[n0+i], 32'hFFFFFFFF);
      chk("clear_cyc", q_cyc[n0+i], c + 1 + i);
    end
    chk("clear_done_last", 32'(q_cd[n0+FW-1]), 1);
    // mid-frame sof after 40 beats
    n0 = q_addr.size();
    for (int p = 0; p < 40; p++) beat(1, 1'($urandom_range(1, 0)), p == 0, 0, 0);
    n1 = q_addr.size();
    chk("restart_pre_writes", n1 - n0, 1);
    chk("restart_pre_addr", q_addr[n0], 0);
    for (int p = 0; p < 32; p++) beat(1, 1'($urandom_range(1, 0)), p == 0, 0, 0);
    chk("restart_post_writes", q_addr.size() - n1, 1);
    chk("restart_post_addr", q_addr[n1], 0);
`ifdef FB_PACKER_STATS_EN
    chk("stats_restarts", 32'(sof_restart_count), 1);
    chk("stats_frames", 32'(frame_count), 1);
`endif
    // random traffic, then a full frame with bubbles
    for (int i = 0; i < 1500; i++)
      beat($urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)), $urandom_range(199, 0) == 0,
           $urandom_range(299, 0) == 0, 1'($urandom_range(1, 0)));
    repeat (FW + 2) beat(0, 0, 0, 0, 0);
    for (int p = 0; p < HP * VL; p++) begin
      if ($urandom_range(3, 0) == 0) beat(0, 0, 0, 0, 0);
      beat(1, 1'($urandom_range(1, 0)), p == 0, 0, 0);
    end
    beat(0, 0, 0, 0, 0);
    // reset while clear word 10 is on the bus
    beat(0, 0, 0, 1, 1);
    repeat (10) beat(0, 0, 0, 0, 0);
    chk("pre_reset_addr", 32'(address), 10);
    reset = 1;
    beat(0, 0, 0, 0, 0);
    chk("reset_write", 32'(write), 0);
    chk("reset_addr", 32'(address), 0);
    chk("reset_data", writedata, 0);
    chk("reset_flags", {29'd0, frame_done, clear_done, busy}, 0);
    chk("reset_ready", 32'(pix_ready), 1);
    reset = 0;
    beat(0, 0, 0, 0, 0);
    n0 = q_addr.size();
    for (int p = 0; p < HP * VL; p++) beat(1, 1'($urandom_range(1, 0)), p == 0, 0, 0);
    beat(0, 0, 0, 0, 0);
    chk("post_reset_first_addr", q_addr[n0], 0);
    chk("post_reset_writes", q_addr.size() - n0, FW);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
